// File: rtl/cv32e40p_encoder_ham.sv
// Hamming(38,32) encoder for the register-file write path, with a 2-entry output FIFO.
// Optional build macro CV32E40P_HAM_FAULT_INJ_EN adds inj_en_i/inj_pos_i for single-bit fault injection.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// a source holds valid and its payload stable until that edge, and ready never depends
// combinationally on the same-side valid nor on the opposite port.
module cv32e40p_encoder_ham #(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [31:0]           in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [37:0]           out_codeword_o,
  output logic [CNT_WIDTH-1:0]  enc_count_o,
  output logic                  fifo_full_o
`ifdef CV32E40P_HAM_FAULT_INJ_EN
  ,
  input  logic                  inj_en_i,
  input  logic [5:0]            inj_pos_i
`endif
);

  // Data lands on non-power-of-two positions; parity k covers positions with bit k set.
  function automatic logic [37:0] ham_encode(input logic [31:0] d);
    logic [37:0] cw;
    logic [5:0]  par;
    cw          = '0;
    cw[2]       = d[0];
    cw[6:4]     = d[3:1];
    cw[14:8]    = d[10:4];
    cw[30:16]   = d[25:11];
    cw[37:32]   = d[31:26];
    par         = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 38; i++) begin
        if (((i + 1) & (1 << k)) != 0) par[k] = par[k] ^ cw[i];
      end
    end
    cw[0]  = par[0];
    cw[1]  = par[1];
    cw[3]  = par[2];
    cw[7]  = par[3];
    cw[15] = par[4];
    cw[31] = par[5];
    return cw;
  endfunction

  logic [37:0]           enc_cw;
  logic [37:0]           inj_mask;
  logic                  push;
  logic                  pop;

  logic [37:0]           mem_cw   [2];
  logic [ADDR_WIDTH-1:0] mem_addr [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [CNT_WIDTH-1:0]  enc_cnt;

`ifdef CV32E40P_HAM_FAULT_INJ_EN
  always_comb begin
    inj_mask = '0;
    if (inj_en_i && (inj_pos_i <= 6'd37)) inj_mask = 38'd1 << inj_pos_i;
  end
`else
  assign inj_mask = '0;
`endif

  assign enc_cw = ham_encode(in_data_i) ^ inj_mask;

  assign in_ready_o     = (count != 2'd2);
  assign fifo_full_o    = (count == 2'd2);
  assign out_valid_o    = (count != 2'd0);
  assign push           = in_valid_i && in_ready_o;
  assign pop            = out_valid_o && out_ready_i;
  assign out_codeword_o = mem_cw[rd_ptr];
  assign out_addr_o     = mem_addr[rd_ptr];
  assign enc_count_o    = enc_cnt;

  // Popped slots are cleared so the head reads as zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cw[0]   <= '0;
      mem_cw[1]   <= '0;
      mem_addr[0] <= '0;
      mem_addr[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      enc_cnt     <= '0;
    end else begin
      if (pop) begin
        mem_cw[rd_ptr]   <= '0;
        mem_addr[rd_ptr] <= '0;
        rd_ptr           <= ~rd_ptr;
      end
      if (push) begin
        mem_cw[wr_ptr]   <= enc_cw;
        mem_addr[wr_ptr] <= in_addr_i;
        wr_ptr           <= ~wr_ptr;
        enc_cnt          <= enc_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_encoder_ham.sv
// Directed self-checking bench for cv32e40p_encoder_ham: encoding vectors, FIFO flow control and reset.
module tb_cv32e40p_encoder_ham;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [5:0]  in_addr_i;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [5:0]  out_addr_o;
  logic [37:0] out_codeword_o;
  logic [15:0] enc_count_o;
  logic        fifo_full_o;
`ifdef CV32E40P_HAM_FAULT_INJ_EN
  logic        inj_en_i;
  logic [5:0]  inj_pos_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_encoder_ham #(.ADDR_WIDTH(6), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_addr_i      (in_addr_i),
    .in_data_i      (in_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_addr_o     (out_addr_o),
    .out_codeword_o (out_codeword_o),
    .enc_count_o    (enc_count_o),
    .fifo_full_o    (fifo_full_o)
`ifdef CV32E40P_HAM_FAULT_INJ_EN
    ,
    .inj_en_i       (inj_en_i),
    .inj_pos_i      (inj_pos_i)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [5:0] a, input logic [31:0] d);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    in_data_i  = d;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_i = 1'b1;
    in_addr_i = 6'd9;
    in_data_i = 32'hDEAD_BEEF;
    step();
    step();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", in_ready_o); end
    n_checks++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", fifo_full_o); end
    n_checks++; if (enc_count_o !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", enc_count_o); end
    n_checks++; if (out_codeword_o !== 38'h0) begin n_fail++; $display("FAIL rst_cw got %h exp 0", out_codeword_o); end
    n_checks++; if (out_addr_o !== 6'd0) begin n_fail++; $display("FAIL rst_addr got %0d exp 0", out_addr_o); end
    in_valid_i = 1'b0;
    rst = 1'b0;
    step();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept got %b exp 0", out_valid_o); end
  endtask

  task automatic test_encode();
    logic [31:0] vec_d  [5];
    logic [37:0] vec_cw [5];
    logic [5:0]  vec_a  [5];
    vec_d[0] = 32'h0000_0000; vec_cw[0] = 38'h00_0000_0000; vec_a[0] = 6'd5;
    vec_d[1] = 32'h0000_0001; vec_cw[1] = 38'h00_0000_0007; vec_a[1] = 6'd6;
    vec_d[2] = 32'h0400_0000; vec_cw[2] = 38'h01_8000_0001; vec_a[2] = 6'd7;
    vec_d[3] = 32'h0000_0800; vec_cw[3] = 38'h00_0001_8001; vec_a[3] = 6'd63;
    vec_d[4] = 32'hFFFF_FFFF; vec_cw[4] = 38'h3F_7FFF_FFF4; vec_a[4] = 6'd0;
    for (int v = 0; v < 5; v++) begin
      push_one(vec_a[v], vec_d[v]);
      n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL enc%0d_valid got %b exp 1", v, out_valid_o); end
      n_checks++; if (out_codeword_o !== vec_cw[v]) begin n_fail++; $display("FAIL enc%0d_cw got %h exp %h", v, out_codeword_o, vec_cw[v]); end
      n_checks++; if (out_addr_o !== vec_a[v]) begin n_fail++; $display("FAIL enc%0d_addr got %0d exp %0d", v, out_addr_o, vec_a[v]); end
      n_checks++; if (enc_count_o !== 16'(v + 1)) begin n_fail++; $display("FAIL enc%0d_count got %0d exp %0d", v, enc_count_o, v + 1); end
      pop_one();
      n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL enc%0d_drain got %b exp 0", v, out_valid_o); end
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_q[$];
    logic [37:0] exp_cw;
    logic [15:0] base;
    base = enc_count_o;
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    in_addr_i = 6'd1; in_data_i = 32'h0000_0001; exp_q.push_back(38'h00_0000_0007);
    step();
    in_addr_i = 6'd2; in_data_i = 32'h0400_0000; exp_q.push_back(38'h01_8000_0001);
    step();
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL b2b_full got %b exp 1", fifo_full_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %b exp 0", in_ready_o); end
    in_addr_i = 6'd3; in_data_i = 32'h0000_0800; exp_q.push_back(38'h00_0001_8001);
    step();
    n_checks++; if (enc_count_o !== base + 16'd2) begin n_fail++; $display("FAIL b2b_refused got %0d exp %0d", enc_count_o, base + 16'd2); end
    n_checks++; if (out_codeword_o !== exp_q[0]) begin n_fail++; $display("FAIL b2b_head_stable got %h exp %h", out_codeword_o, exp_q[0]); end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    void'(exp_q.pop_front());
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got %b exp 1", in_ready_o); end
    n_checks++; if (out_codeword_o !== exp_q[0]) begin n_fail++; $display("FAIL b2b_head2 got %h exp %h", out_codeword_o, exp_q[0]); end
    step();
    in_valid_i = 1'b0;
    n_checks++; if (enc_count_o !== base + 16'd3) begin n_fail++; $display("FAIL b2b_third got %0d exp %0d", enc_count_o, base + 16'd3); end
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL b2b_full2 got %b exp 1", fifo_full_o); end
    for (int i = 0; i < 2; i++) begin
      exp_cw = exp_q.pop_front();
      n_checks++; if (out_codeword_o !== exp_cw) begin n_fail++; $display("FAIL b2b_order%0d got %h exp %h", i, out_codeword_o, exp_cw); end
      n_checks++; if (out_addr_o !== 6'(i + 2)) begin n_fail++; $display("FAIL b2b_addr%0d got %0d exp %0d", i, out_addr_o, i + 2); end
      pop_one();
    end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b exp 0", out_valid_o); end
    n_checks++; if (out_codeword_o !== 38'h0) begin n_fail++; $display("FAIL b2b_empty_cw got %h exp 0", out_codeword_o); end
  endtask

  task automatic test_push_pop_same_cycle();
    push_one(6'd10, 32'h0000_0001);
    in_valid_i = 1'b1; in_addr_i = 6'd11; in_data_i = 32'h0400_0000;
    out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b1 || fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL pp_count got valid=%b full=%b exp valid=1 full=0", out_valid_o, fifo_full_o); end
    n_checks++; if (out_codeword_o !== 38'h01_8000_0001) begin n_fail++; $display("FAIL pp_head got %h exp %h", out_codeword_o, 38'h01_8000_0001); end
    n_checks++; if (out_addr_o !== 6'd11) begin n_fail++; $display("FAIL pp_addr got %0d exp 11", out_addr_o); end
    pop_one();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL pp_drain got %b exp 0", out_valid_o); end
  endtask

  task automatic test_reset_mid();
    push_one(6'd20, 32'h0000_0001);
    push_one(6'd21, 32'h0000_0800);
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL rmid_full got %b exp 1", fifo_full_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid_o); end
    n_checks++; if (enc_count_o !== 16'd0) begin n_fail++; $display("FAIL rmid_count got %0d exp 0", enc_count_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", in_ready_o); end
    n_checks++; if (out_codeword_o !== 38'h0) begin n_fail++; $display("FAIL rmid_cw got %h exp 0", out_codeword_o); end
  endtask

`ifdef CV32E40P_HAM_FAULT_INJ_EN
  task automatic test_fault_inj();
    logic [5:0]  syn;
    logic [37:0] fixed;
    inj_en_i = 1'b1; inj_pos_i = 6'd2;
    push_one(6'd4, 32'h0000_0001);
    inj_en_i = 1'b0;
    n_checks++; if (out_codeword_o !== 38'h00_0000_0003) begin n_fail++; $display("FAIL inj_cw got %h exp %h", out_codeword_o, 38'h00_0000_0003); end
    syn = '0;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 38; i++)
        if (((i + 1) & (1 << k)) != 0) syn[k] = syn[k] ^ out_codeword_o[i];
    n_checks++; if (syn !== 6'd3) begin n_fail++; $display("FAIL inj_syndrome got %0d exp 3", syn); end
    fixed = out_codeword_o;
    if (syn != 6'd0 && syn <= 6'd38) fixed[syn - 6'd1] = ~fixed[syn - 6'd1];
    n_checks++; if (fixed[2] !== 1'b1 || fixed[37:32] !== 6'd0 || fixed[30:16] !== 15'd0) begin n_fail++; $display("FAIL inj_corrected got %h exp data 1", fixed); end
    pop_one();
    inj_en_i = 1'b1; inj_pos_i = 6'd40;
    push_one(6'd4, 32'h0000_0001);
    inj_en_i = 1'b0;
    n_checks++; if (out_codeword_o !== 38'h00_0000_0007) begin n_fail++; $display("FAIL inj_oob got %h exp %h", out_codeword_o, 38'h00_0000_0007); end
    pop_one();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid_i = 1'b0;
    in_addr_i = '0;
    in_data_i = '0;
    out_ready_i = 1'b0;
`ifdef CV32E40P_HAM_FAULT_INJ_EN
    inj_en_i = 1'b0;
    inj_pos_i = '0;
`endif
    test_reset();
    test_encode();
    test_back_to_back();
    test_push_pop_same_cycle();
    test_reset_mid();
`ifdef CV32E40P_HAM_FAULT_INJ_EN
    test_fault_inj();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
